// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access controller.
// Provides the RV32 load/store size codes, the controller state encoding,
// the default array depth and a funct3 legality helper.
package sram_pkg;

    localparam int unsigned DEFAULT_DEPTH = 64;

    // RV32 load/store funct3 size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

    // Unknown codes are illegal; the unsigned forms are legal only for loads.
    function automatic logic funct3_illegal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// LSU-side request/response bundle of the SRAM access controller.
// master: the LSU (drives requests, accepts responses).
// slave:  the controller (accepts requests, drives responses).
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_lane_align.sv
// Byte-lane alignment for the SRAM access controller (purely combinational).
// Ports:
//   funct3_i      size/sign code
//   addr_lo_i     byte offset within the word
//   wdata_i       right-aligned store data
//   rdata_i       raw array word
//   byte_sel_o    per-byte lane enables
//   sram_datain_o store data replicated across lanes
//   rdata_ext_o   extracted, sign/zero-extended load data
//   misalign_o    access not naturally aligned for its size
module sram_lane_align
    import sram_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_sel_o,
    output logic [31:0] sram_datain_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign rd_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        byte_sel_o    = 4'b0000;
        sram_datain_o = 32'h0;
        rdata_ext_o   = 32'h0;
        misalign_o    = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                byte_sel_o    = 4'b0001 << addr_lo_i;
                sram_datain_o = {4{wdata_i[7:0]}};
                rdata_ext_o   = (funct3_i == F3_B) ? {{24{rd_byte[7]}}, rd_byte}
                                                   : {24'h0, rd_byte};
            end
            F3_H, F3_HU: begin
                misalign_o    = addr_lo_i[0];
                byte_sel_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                sram_datain_o = {2{wdata_i[15:0]}};
                rdata_ext_o   = (funct3_i == F3_H) ? {{16{rd_half[15]}}, rd_half}
                                                   : {16'h0, rd_half};
            end
            F3_W: begin
                misalign_o    = |addr_lo_i;
                byte_sel_o    = 4'b1111;
                sram_datain_o = wdata_i;
                rdata_ext_o   = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Initiator side of the SRAM word array: accepts one LSU load/store at a time,
// drives the array for one cycle and returns a single response.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   bus            LSU request/response handshake (slave side)
//   wordline       one-hot word select
//   byte_sel       per-byte lane enables
//   sram_datain    lane-replicated write data
//   read_enable    array read strobe
//   write_enable   array write strobe
//   sram_dataout   array read word, valid the cycle after read_enable
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_access_ctrl_if.slave bus,
    output logic [DEPTH-1:0]  wordline,
    output logic [3:0]        byte_sel,
    output logic [31:0]       sram_datain,
    output logic              read_enable,
    output logic              write_enable,
    input  logic [31:0]       sram_dataout
);

    localparam int unsigned       IdxW   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DepthW = ADDR_W'(DEPTH);

    state_e           state_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             we_q;
    logic [DEPTH-1:0] wordline_q;
    logic [3:0]       byte_sel_q;
    logic [31:0]      sram_datain_q;
    logic             read_enable_q;
    logic             write_enable_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic [2:0]  la_funct3;
    logic [1:0]  la_addr_lo;
    logic [3:0]  la_byte_sel;
    logic [31:0] la_datain;
    logic [31:0] la_rdata_ext;
    logic        la_misalign;
    logic        out_of_range;
    logic        req_bad;

    // The aligner sees the incoming request while idle (to set up the access)
    // and the registered request afterwards (to extract load data).
    assign la_funct3  = (state_q == IDLE) ? bus.req_funct3    : funct3_q;
    assign la_addr_lo = (state_q == IDLE) ? bus.req_addr[1:0] : addr_lo_q;

    sram_lane_align u_lane_align (
        .funct3_i      (la_funct3),
        .addr_lo_i     (la_addr_lo),
        .wdata_i       (bus.req_wdata),
        .rdata_i       (sram_dataout),
        .byte_sel_o    (la_byte_sel),
        .sram_datain_o (la_datain),
        .rdata_ext_o   (la_rdata_ext),
        .misalign_o    (la_misalign)
    );

    assign out_of_range = {2'b00, bus.req_addr[ADDR_W-1:2]} >= DepthW;
    assign req_bad      = la_misalign | out_of_range
                        | funct3_illegal(bus.req_funct3, bus.req_we);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
            we_q           <= 1'b0;
            wordline_q     <= '0;
            byte_sel_q     <= 4'b0000;
            sram_datain_q  <= 32'h0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'h0;
            rsp_err_q      <= 1'b0;
        end else begin
            // Array strobes last exactly one cycle unless re-armed below.
            wordline_q     <= '0;
            byte_sel_q     <= 4'b0000;
            sram_datain_q  <= 32'h0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q  <= bus.req_funct3;
                        addr_lo_q <= bus.req_addr[1:0];
                        we_q      <= bus.req_we;
                        if (req_bad) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q        <= ACCESS;
                            wordline_q     <= {{(DEPTH-1){1'b0}}, 1'b1}
                                              << bus.req_addr[IdxW+1:2];
                            byte_sel_q     <= la_byte_sel;
                            sram_datain_q  <= la_datain;
                            write_enable_q <= bus.req_we;
                            read_enable_q  <= ~bus.req_we;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= la_rdata_ext;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Array outputs are killed while reset is low so an access that is in
    // flight when reset arrives never reaches the array.
    assign wordline     = rst_n ? wordline_q    : '0;
    assign byte_sel     = rst_n ? byte_sel_q    : 4'b0000;
    assign sram_datain  = rst_n ? sram_datain_q : 32'h0;
    assign read_enable  = rst_n & read_enable_q;
    assign write_enable = rst_n & write_enable_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: directed scenarios followed by
// randomized requests, scored against a byte-addressed reference memory.
module tb_sram_access_ctrl;

    localparam int unsigned DEPTH = 64;

    logic              clk;
    logic              rst_n;
    logic [DEPTH-1:0]  wordline;
    logic [3:0]        byte_sel;
    logic [31:0]       sram_datain;
    logic              read_enable;
    logic              write_enable;
    logic [31:0]       sram_dataout;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] sram_mem [DEPTH];
    logic [31:0] last_rdata;
    int unsigned wl_idx;
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    sram_access_ctrl_if #(.ADDR_W(32)) bus ();

    sram_access_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .wordline     (wordline),
        .byte_sel     (byte_sel),
        .sram_datain  (sram_datain),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .sram_dataout (sram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple array model driven by the DUT's strobes.
    always_comb begin
        wl_idx = 0;
        for (int i = 0; i < DEPTH; i++) if (wordline[i]) wl_idx = i;
    end

    always @(posedge clk) begin
        if (write_enable)
            for (int i = 0; i < 4; i++)
                if (byte_sel[i]) sram_mem[wl_idx][8*i +: 8] <= sram_datain[8*i +: 8];
        if (read_enable) sram_dataout <= sram_mem[wl_idx];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Issue one request (caller is just after a posedge) and score it.
    // Returns just after the response handshake edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int unsigned hold);
        int unsigned sz, a, word, off, lat, exp_lat, idle_bad, busy_bad;
        logic        err, sgn;
        logic [3:0]  exp_bs;
        logic [31:0] exp_din, exp_rd, v, m;
        logic [63:0] exp_wl;
        a   = addr;
        sz  = size_of(f3);
        sgn = (f3 == 3'b000) || (f3 == 3'b001);
        err = (sz == 0) || (we && f3[2]) || (a / 4 >= DEPTH) || (a % sz != 0);
        word = a / 4;
        off  = a % 4;
        exp_bs = 4'b0; exp_din = 32'h0; exp_rd = 32'h0; exp_wl = 64'h0;
        if (!err) begin
            exp_wl = 64'd1 << word;
            exp_bs = 4'(((32'd1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++) exp_din[8*i +: 8] = wd[8*(i % sz) +: 8];
            if (we) begin
                for (int i = 0; i < sz; i++) ref_mem[word][8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                v = ref_mem[word] >> (8 * off);
                m = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
                v = v & m;
                if (sgn && v[8*sz-1]) v = v | ~m;
                exp_rd = v;
            end
        end
        exp_lat = err ? 1 : (we ? 2 : 3);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = (hold == 0);
        @(negedge clk);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        lat = 0; idle_bad = 0; busy_bad = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1 && !err) begin
                chk("wordline", 64'(wordline), exp_wl);
                chk("byte_sel", 64'(byte_sel), 64'(exp_bs));
                chk("write_enable", 64'(write_enable), 64'(we));
                chk("read_enable", 64'(read_enable), 64'(!we));
                if (we) chk("sram_datain", 64'(sram_datain), 64'(exp_din));
            end else if (wordline != 0 || byte_sel != 0 || read_enable || write_enable
                         || sram_datain != 0) begin
                idle_bad++;
            end
            if (bus.req_ready) busy_bad++;
            if (bus.rsp_valid) lat = c;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_err", 64'(bus.rsp_err), 64'(err));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        chk("sram_quiet", 64'(idle_bad), 64'd0);
        chk("busy_not_ready", 64'(busy_bad), 64'd0);
        last_rdata = bus.rsp_rdata;

        if (lat != 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
                chk("hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
                chk("hold_err", 64'(bus.rsp_err), 64'(err));
                chk("hold_not_ready", 64'(bus.req_ready), 64'd0);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] ad, old;
        int unsigned sz, r, bad;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_wordline", 64'(wordline), 64'd0);
        chk("rst_strobes", 64'({read_enable, write_enable}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill the array so both memory images agree.
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'b010, 32'(4 * w), $urandom, 0);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
        chk("lw_deadbeef", 64'(last_rdata), 64'hDEAD_BEEF);
        do_req(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
        chk("lb_const", 64'(last_rdata), 64'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
        chk("lbu_const", 64'(last_rdata), 64'h0000_0080);
        do_req(1'b1, 3'b001, 32'h06, 32'h0000_1234, 0);
        do_req(1'b1, 3'b010, 32'h04, 32'h8001_0000, 0);
        do_req(1'b0, 3'b001, 32'h06, 32'h0, 0);
        chk("lh_const", 64'(last_rdata), 64'hFFFF_8001);

        // Error cases
        do_req(1'b0, 3'b010, 32'h02, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h01, 32'h5555_5555, 0);
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h08, 32'h0000_00AA, 0);

        // Backpressure on a load
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5);

        // Reset during the ACCESS cycle of a store drops it silently.
        old = ref_mem[9];
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'd36; bus.req_wdata = ~old; bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_access_we", 64'(write_enable), 64'd0);
        chk("rst_access_wl", 64'(wordline), 64'd0);
        chk("rst_access_bs", 64'({byte_sel, sram_datain}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        chk("post_rst_outs", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
                                  read_enable, write_enable}), 64'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
        end
        chk("dropped_no_rsp", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        do_req(1'b0, 3'b010, 32'd36, 32'h0, 0);
        chk("dropped_no_write", 64'(last_rdata), 64'(old));

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            f3 = (($urandom % 8) == 0) ? 3'($urandom) : legal_f3[$urandom % 5];
            r  = $urandom % 10;
            ad = (r == 0) ? $urandom : $urandom_range(0, 4 * DEPTH - 1);
            sz = size_of(f3);
            if (r >= 4 && sz != 0) ad = ad & ~32'(sz - 1);
            do_req(1'($urandom), f3, ad, $urandom,
                   (($urandom % 4) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Initiator side of the SRAM word array. It accepts one load or store request at a time from the core LSU over a valid/ready handshake.
- It decodes the word address to a one-hot wordline, generates byte_sel and lane-replicated write data, and drives read_enable/write_enable.
- On loads it captures the 32-bit word and extracts and sign/zero-extends the addressed byte or halfword.
- It returns a single response with an error flag for misaligned, out-of-range or illegal requests.

Parameters:
- DEPTH, 64, number of 32-bit words in the array (one wordline each).
- ADDR_W, 32, width of the byte address from the LSU.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  LSU accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal funct3.
- wordline  out  DEPTH  one-hot word select.
- byte_sel  out  4  per-byte lane enable.
- sram_datain  out  32  lane-positioned write data.
- read_enable  out  1  array read strobe.
- write_enable  out  1  array write strobe.
- sram_dataout  in  32  array read word, valid the cycle after the read strobe.

Behaviour:
- Reset: synchronous. When rst_n = 0 at a clk edge:
  - state goes to IDLE and the in-flight request is dropped.
  - All outputs are 0, except req_ready, which is 1 once in IDLE.
  - No write is issued in the reset cycle, even if the controller was in ACCESS.
- Handshake:
  - A request is accepted on a clk edge with req_valid & req_ready; all request fields are registered at that edge.
  - req_ready = 1 only in IDLE.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
- State IDLE: on accept, check the request.
  - If the check fails, go to RESP with rsp_err = 1. Otherwise go to ACCESS.
- Check fails when any of:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - funct3 is not one of the five legal codes.
  - A store uses 100 or 101.
  - Word index addr[ADDR_W-1:2] >= DEPTH.
- State ACCESS (exactly 1 cycle):
  - wordline = 1 << addr[$clog2(DEPTH)+1:2].
  - byte_sel: B/BU = 1 << addr[1:0]; H/HU = 0011 when addr[1] = 0, 1100 when addr[1] = 1; W = 1111.
  - Store: write_enable = 1. sram_datain = {4{wdata[7:0]}} for B, {2{wdata[15:0]}} for H, wdata for W. Next state RESP.
  - Load: read_enable = 1. Next state CAPTURE.
- State CAPTURE (1 cycle, loads only):
  - All SRAM outputs are 0.
  - sram_dataout is registered and lane-extracted using addr[1:0].
  - B sign-extends bit 7 of the byte; BU zero-extends; H sign-extends bit 15 of the half; HU zero-extends; W passes through.
  - Next state RESP.
- State RESP:
  - rsp_valid = 1. When rsp_ready = 1, go to IDLE.
  - Back-to-back throughput: the next request is accepted the cycle after the response handshake.
- SRAM-side outputs (wordline, byte_sel, sram_datain, read_enable, write_enable) are 0 in every state except ACCESS. Out-of-range or erroneous requests never assert wordline.
- Latency, accept edge = cycle 0, assuming rsp_ready = 1:
  - Load: ACCESS in cycle 1, CAPTURE in cycle 2, rsp_valid in cycle 3.
  - Store: rsp_valid in cycle 2.
  - Error: rsp_valid in cycle 1.
- read_enable and write_enable are never asserted together.

Decomposition:
- Shared package sram_pkg holds:
  - the funct3 codes F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - the state enum IDLE/ACCESS/CAPTURE/RESP.
  - the default DEPTH constant.
- One combinational sub-module, sram_lane_align: given funct3, addr[1:0], wdata and rdata, it produces byte_sel, sram_datain, the extended load data, and the misalignment flag.
- The FSM and registers live in sram_access_ctrl.

Test Plan:
- SW addr 0x0000_0010, wdata 0xDEADBEEF -> cycle 1: wordline bit 4, byte_sel 1111, sram_datain 0xDEADBEEF, write_enable 1; cycle 2: rsp_valid 1, rsp_err 0, rsp_rdata 0.
- LB addr 0x13, sram_dataout 0x80FF_7F01 -> byte_sel 1000, read_enable for 1 cycle, rsp_rdata 0xFFFF_FF80 at cycle 3; repeat as LBU -> 0x0000_0080.
- SH addr 0x06, wdata 0x0000_1234 -> byte_sel 1100, sram_datain 0x1234_1234; LH addr 0x06, dataout 0x8001_0000 -> rsp_rdata 0xFFFF_8001.
- Error cases: LW addr 0x02, SH addr 0x01, funct3 011, and LW addr 4*DEPTH -> each gives rsp_valid at cycle 1 with rsp_err 1, and wordline, read_enable and write_enable stay 0 throughout.
- Backpressure: hold rsp_ready 0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready 0; the new request is accepted the cycle after rsp_ready rises.
- Assert rst_n = 0 during the ACCESS cycle of a store -> write_enable 0 that cycle, all outputs 0, req_ready 1 after reset releases, and no response is ever emitted for the dropped request.
